// File: rtl/sensor_sched_pkg.sv
// Shared types for the sensor acquisition scheduler.
// Display width and controller state encoding.
package sensor_sched_pkg;

    localparam int DISP_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        UPDATE
    } state_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector.
// rise is high for one cycle when the synchronized input goes 0 -> 1.
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic [2:0] sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh <= '0;
        end else begin
            sh <= {sh[1:0], din};
        end
    end

    assign rise = sh[1] & ~sh[2];

endmodule

// File: rtl/sensor_scheduler.sv
// Arbitrates periodic and button acquisition requests, drives the SPI
// start pulse, waits for done with a timeout, and updates the display.
module sensor_scheduler
    import sensor_sched_pkg::*;
#(
    parameter int PERIOD_CYCLES  = 10_000_000,
    parameter int TIMEOUT_CYCLES = 100_000
) (
    input  logic              clk_pi,
    input  logic              reset_pi,
    input  logic              enable_pi,
    input  logic              boton_pi,
    input  logic              done_pi,
    input  logic [31:0]       data_pi,
    output logic              start_po,
    output logic              we_7seg_po,
    output logic [DISP_W-1:0] d_7seg_po,
    output logic [15:0]       sample_count_po,
    output logic              timeout_po,
    output logic              busy_po
);

    localparam int PW = $clog2(PERIOD_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [PW-1:0] PER_LAST = PW'(PERIOD_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic        man_rise;
    logic        pend_man;
    logic        pend_per;
    logic        per_wrap;
    logic        grant;
    logic [PW-1:0] per_cnt;
    logic [TW-1:0] tcnt;
    logic [15:0] sample_cnt;
    logic        unused_hi;

    assign unused_hi = ^data_pi[31:16];

    edge_sync u_btn (
        .clk   (clk_pi),
        .rst_n (reset_pi),
        .din   (boton_pi),
        .rise  (man_rise)
    );

    assign per_wrap = enable_pi && (per_cnt == PER_LAST);
    assign grant    = (state == IDLE) && (pend_man || pend_per);

    always_ff @(posedge clk_pi or negedge reset_pi) begin
        if (!reset_pi) begin
            per_cnt <= '0;
        end else if (!enable_pi || per_wrap) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + 1'b1;
        end
    end

    // A new request in the grant cycle survives the clear.
    always_ff @(posedge clk_pi or negedge reset_pi) begin
        if (!reset_pi) begin
            pend_man <= 1'b0;
            pend_per <= 1'b0;
        end else begin
            pend_man <= man_rise | (pend_man & ~grant);
            pend_per <= per_wrap | (pend_per & ~grant);
        end
    end

    // tcnt counts cycles elapsed since the start_po cycle.
    always_ff @(posedge clk_pi or negedge reset_pi) begin
        if (!reset_pi) begin
            state      <= IDLE;
            start_po   <= 1'b0;
            we_7seg_po <= 1'b0;
            d_7seg_po  <= '0;
            sample_cnt <= '0;
            timeout_po <= 1'b0;
            tcnt       <= '0;
        end else begin
            start_po   <= 1'b0;
            we_7seg_po <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant) begin
                        state    <= START;
                        start_po <= 1'b1;
                        tcnt     <= '0;
                    end
                end
                START: begin
                    state <= WAIT;
                    tcnt  <= tcnt + 1'b1;
                end
                WAIT: begin
                    if (done_pi) begin
                        d_7seg_po  <= data_pi[DISP_W-1:0];
                        we_7seg_po <= 1'b1;
                        state      <= UPDATE;
                    end else if (tcnt == TO_LAST) begin
                        timeout_po <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                UPDATE: begin
                    sample_cnt <= sample_cnt + 16'd1;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign sample_count_po = sample_cnt;
    assign busy_po         = (state != IDLE);

endmodule

// File: tb/tb_sensor_scheduler.sv
// Self-checking bench for sensor_scheduler: vector table, scoreboard
// on display writes, and hand-written periodic/merge/reset sequences.
module tb_sensor_scheduler;

    localparam int P = 20;
    localparam int T = 8;

    logic        clk_pi = 1'b0;
    logic        reset_pi = 1'b0;
    logic        enable_pi = 1'b0;
    logic        boton_pi = 1'b0;
    logic        resp_done = 1'b0;
    logic        spur_done = 1'b0;
    logic        done_pi;
    logic [31:0] data_pi = '0;
    logic        start_po;
    logic        we_7seg_po;
    logic [15:0] d_7seg_po;
    logic [15:0] sample_count_po;
    logic        timeout_po;
    logic        busy_po;

    assign done_pi = resp_done | spur_done;

    sensor_scheduler #(
        .PERIOD_CYCLES  (P),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk_pi          (clk_pi),
        .reset_pi        (reset_pi),
        .enable_pi       (enable_pi),
        .boton_pi        (boton_pi),
        .done_pi         (done_pi),
        .data_pi         (data_pi),
        .start_po        (start_po),
        .we_7seg_po      (we_7seg_po),
        .d_7seg_po       (d_7seg_po),
        .sample_count_po (sample_count_po),
        .timeout_po      (timeout_po),
        .busy_po         (busy_po)
    );

    always #50 clk_pi = ~clk_pi;

    int cyc = 0;
    always @(posedge clk_pi) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] d;
        logic [15:0] c;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] exp_cnt = '0;
    int          resp_delay = 3;
    logic [31:0] resp_data = 32'hDEAD1234;
    int          rcnt = 0;
    int          start_cnt = 0;
    int          last_start = -1;
    int          we_cnt = 0;
    int          to_rise = -1;
    logic        to_prev = 1'b0;
    logic        cnt_chk = 1'b0;
    logic [15:0] cnt_exp = '0;

    // Monitor, scoreboard and SPI responder model.
    always @(negedge clk_pi) begin
        if (cnt_chk) begin
            chk("sample_count", sample_count_po, cnt_exp);
            cnt_chk = 1'b0;
        end
        if (we_7seg_po) begin
            we_cnt++;
            chk("we_after_done", done_pi, 1);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL we_unexpected: got we=1 want 0");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("d_7seg", d_7seg_po, e.d);
                cnt_chk = 1'b1;
                cnt_exp = e.c;
            end
        end
        if (timeout_po && !to_prev) to_rise = cyc;
        to_prev = timeout_po;
        if (!reset_pi) begin
            rcnt = 0;
            resp_done = 1'b0;
        end else begin
            resp_done = 1'b0;
            if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) resp_done = 1'b1;
            end
            if (start_po) begin
                start_cnt++;
                last_start = cyc;
                rcnt = resp_delay;
                data_pi = resp_data;
                if (resp_delay >= 1 && resp_delay < T) begin
                    exp_t e;
                    exp_cnt = exp_cnt + 16'd1;
                    e.d = resp_data[15:0];
                    e.c = exp_cnt;
                    exp_q.push_back(e);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk_pi);
        #1;
    endtask

    task automatic wait_start(output int s);
        s = -1;
        for (int k = 0; k < 60; k++) begin
            step();
            if (start_po) begin
                s = cyc;
                break;
            end
        end
        if (s < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL start_wait: got none want start_po");
        end
    endtask

    task automatic wait_idle();
        int ok;
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            if (!busy_po) begin
                ok = 1;
                break;
            end
            step();
        end
        if (ok == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_wait: got busy want idle");
        end
    endtask

    task automatic txn(input string nm);
        int b;
        int s;
        b = cyc;
        boton_pi = 1'b1;
        step();
        step();
        boton_pi = 1'b0;
        wait_start(s);
        chk({nm, "_lat"}, s - b, 4);
        wait_idle();
        step();
    endtask

    typedef struct {
        int          dly;
        logic [31:0] data;
        logic [15:0] d;
        logic [15:0] c;
        logic        to;
    } vec_t;

    vec_t tv[6];

    initial begin
        int s1, s2, s3, s, b, sc, wc;
        logic [9:0] pat;

        tv[0] = '{3, 32'hDEAD1234, 16'h1234, 16'd1, 1'b0};
        tv[1] = '{1, 32'h0000BEEF, 16'hBEEF, 16'd2, 1'b0};
        tv[2] = '{7, 32'h5555A5A5, 16'hA5A5, 16'd3, 1'b0};
        tv[3] = '{0, 32'h11112222, 16'hA5A5, 16'd3, 1'b1};
        tv[4] = '{8, 32'h33334444, 16'hA5A5, 16'd3, 1'b1};
        tv[5] = '{2, 32'hFFFF0F0F, 16'h0F0F, 16'd4, 1'b1};

        step();
        step();
        chk("rst_start", start_po, 0);
        chk("rst_we", we_7seg_po, 0);
        chk("rst_d", d_7seg_po, 0);
        chk("rst_count", sample_count_po, 0);
        chk("rst_timeout", timeout_po, 0);
        chk("rst_busy", busy_po, 0);
        reset_pi = 1'b1;
        repeat (3) step();

        for (int i = 0; i < 6; i++) begin
            resp_delay = tv[i].dly;
            resp_data  = tv[i].data;
            txn("vec");
            chk("vec_d", d_7seg_po, tv[i].d);
            chk("vec_count", sample_count_po, tv[i].c);
            chk("vec_timeout", timeout_po, tv[i].to);
            if (tv[i].dly == 0) chk("timeout_cycle", to_rise, last_start + T);
        end
        repeat (50) step();
        chk("no_periodic", start_cnt, 6);

        resp_delay = 3;
        resp_data  = 32'hDEAD1234;
        enable_pi  = 1'b1;
        b = cyc;
        wait_start(s1);
        chk("per_first", s1 - b, P + 1);
        wait_start(s2);
        chk("per_gap1", s2 - s1, P);
        wait_start(s3);
        chk("per_gap2", s3 - s2, P);
        chk("per_d", d_7seg_po, 16'h1234);

        step();
        resp_delay = 7;
        resp_data  = 32'hCAFE5678;
        while (cyc < s3 + 10) step();
        b = cyc;
        sc = start_cnt;
        pat = 10'b0101010011;
        for (int k = 0; k < 10; k++) begin
            boton_pi = pat[k];
            step();
        end
        boton_pi = 1'b0;
        chk("merge_trig_cnt", start_cnt, sc + 1);
        chk("merge_trig_cyc", last_start, b + 4);
        wait_start(s);
        chk("merge_extra_cyc", s, b + 14);
        enable_pi = 1'b0;
        sc = start_cnt;
        repeat (40) step();
        chk("merge_no_more", start_cnt, sc);
        chk("merge_d", d_7seg_po, 16'h5678);

        resp_delay = 0;
        boton_pi = 1'b1;
        step();
        step();
        boton_pi = 1'b0;
        wait_start(s);
        step();
        step();
        wc = we_cnt;
        reset_pi = 1'b0;
        spur_done = 1'b1;
        exp_q.delete();
        exp_cnt = '0;
        #1;
        chk("midrst_start", start_po, 0);
        chk("midrst_we", we_7seg_po, 0);
        chk("midrst_d", d_7seg_po, 0);
        chk("midrst_count", sample_count_po, 0);
        chk("midrst_timeout", timeout_po, 0);
        chk("midrst_busy", busy_po, 0);
        repeat (3) step();
        chk("midrst_hold_we", we_cnt, wc);
        spur_done = 1'b0;
        reset_pi = 1'b1;
        sc = start_cnt;
        repeat (20) step();
        chk("postrst_starts", start_cnt, sc);
        chk("postrst_we", we_cnt, wc);
        chk("postrst_timeout", timeout_po, 0);

        force dut.sample_cnt = 16'hFFFE;
        step();
        release dut.sample_cnt;
        exp_cnt = 16'hFFFE;
        chk("preset_count", sample_count_po, 16'hFFFE);
        resp_delay = 2;
        resp_data  = 32'h0000ABCD;
        txn("wrap1");
        chk("wrap1_count", sample_count_po, 16'hFFFF);
        resp_data  = 32'h00001357;
        txn("wrap2");
        chk("wrap2_count", sample_count_po, 16'h0000);
        chk("wrap2_d", d_7seg_po, 16'h1357);
        chk("sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
